complex_exe_pipe: RTL and testbench
===================================

COMPLEX_EXE_PIPE -- requirements
Module: complex_exe_pipe

Interface
REQ-001 SHALL have parameter MULT_LAT, default 3, cycles from issue to writeback for multiply/syscall-class ops (range 1..7).
REQ-002 SHALL have parameter DIV_LAT, default 8, cycles from issue to writeback for divide-class ops (must exceed MULT_LAT, max 31).
REQ-003 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port issue_valid_i  in  1  complex op issued this cycle.
REQ-006 SHALL have port opcode_i  in  SIZE_OPCODE_I  opcode of issued op.
REQ-007 SHALL have port alu_result_i  in  SIZE_DATA  combinational complex-ALU result, low half.
REQ-008 SHALL have port alu_flags_i  in  EXECUTION_FLAGS  combinational complex-ALU flags.
REQ-009 SHALL have port tag_i  in  SIZE_PHYSICAL_LOG  destination physical register.
REQ-010 SHALL have port rob_i  in  SIZE_ACTIVELIST_LOG  active-list index.
REQ-011 SHALL have port mult_ready_o  out  1  mult-class issue accepted this cycle.
REQ-012 SHALL have port div_ready_o  out  1  div-class issue accepted this cycle.
REQ-013 SHALL have ports wb_valid_o (1), wb_result_o (SIZE_DATA), wb_flags_o (EXECUTION_FLAGS), wb_tag_o (SIZE_PHYSICAL_LOG), wb_rob_o (SIZE_ACTIVELIST_LOG), all out, registered writeback packet.

Function
REQ-014 SHALL classify DIV_L, DIV_H, DIVU_L, DIVU_H as div-class; every other opcode as mult-class.
REQ-015 SHALL capture {result, flags, tag, rob} of an accepted mult-class op into a MULT_LAT-deep shift pipeline advancing every cycle; wb_valid_o asserts exactly MULT_LAT cycles after the issue edge.
REQ-016 SHALL capture an accepted div-class op into a single holding register, load a down-counter with DIV_LAT-1, and assert wb_valid_o exactly DIV_LAT cycles after the issue edge.
REQ-017 SHALL deassert div_ready_o while a div is in flight (non-pipelined divider); div_ready_o re-asserts in the cycle wb_valid_o presents that div.
REQ-018 SHALL deassert mult_ready_o when the in-flight div's remaining cycles equal MULT_LAT, guaranteeing no writeback collision.
REQ-019 SHALL ignore an issue when the corresponding ready is low (no state change); bench flags it as protocol error.
REQ-020 SHALL drive wb_valid_o for exactly one cycle per accepted op; at most one op completes per cycle.
REQ-021 SHALL hold wb_result_o/flags/tag/rob at zero when wb_valid_o is low.
REQ-022 SHALL accept one mult per cycle back-to-back with full throughput.

Reset
REQ-023 SHALL, on reset assertion (any time, mid-operation included), immediately clear all pipeline valids, the div counter and holding register, and drive every wb_* output to 0.
REQ-024 SHALL drive mult_ready_o=1 and div_ready_o=1 while and after reset; in-flight ops are discarded, not written back.

Configuration
REQ-025 SHALL, with COMPLEX_PIPE_FLUSH_EN defined, add input flush_i (1 bit): on a flush edge all in-flight ops and any same-cycle issue are dropped, wb_valid_o is 0 next cycle, readies return to 1.
REQ-026 SHALL, without COMPLEX_PIPE_FLUSH_EN, have no flush_i port; in-flight ops always drain.

Structure
REQ-027 SHALL take opcode-class decode function, default latency constants and the writeback packet struct from the shared execute package.
REQ-028 SHALL instantiate one sub-module, complex_mult_delay, implementing the MULT_LAT shift pipeline; div counter and output mux stay in the top.

Verification
REQ-029 Mult MULT_L at cycle 0, result 0x0000_0006, tag 5 -> wb_valid_o=1 at cycle 3 with result 6, tag 5, flags 6'b011100.
REQ-030 Four mults back-to-back cycles 0-3, tags 1..4 -> writebacks cycles 3-6, tags 1..4 in order, no gaps.
REQ-031 DIVU_L at cycle 0, rob 9 -> div_ready_o=0 cycles 1-7, wb at cycle 8 rob 9, div_ready_o=1 at cycle 8; second div at cycle 2 ignored.
REQ-032 DIV at cycle 0 then mult attempted cycle 5 -> mult_ready_o=0 at cycle 5, mults at cycles 4 and 6 accepted, writebacks at 7, 8 (div), 9.
REQ-033 Reset pulsed at cycle 2 with mult and div in flight -> all wb_* 0 immediately, no later writeback, both readies 1.
REQ-034 With COMPLEX_PIPE_FLUSH_EN: flush_i at cycle 1 alongside a new mult issue -> no writeback for either op, readies 1 at cycle 2.

Source files
------------

// File: rtl/complex_exe_pipe_pkg.sv
// complex_exe_pipe_pkg
// Shared execute-stage definitions for the complex execution pipe:
//   - bus widths (opcode, data, flags, physical tag, active-list index)
//   - default writeback latencies for mult-class and div-class ops
//   - complex opcode encoding and the div-class decode function
//   - the writeback packet struct carried through the pipe
package complex_exe_pipe_pkg;

    localparam int SIZE_OPCODE_I       = 6;
    localparam int SIZE_DATA           = 32;
    localparam int EXECUTION_FLAGS     = 6;
    localparam int SIZE_PHYSICAL_LOG   = 6;
    localparam int SIZE_ACTIVELIST_LOG = 5;

    localparam int DEFAULT_MULT_LAT = 3;
    localparam int DEFAULT_DIV_LAT  = 8;

    // Wide enough for the largest divide latency (31).
    localparam int DIV_CNT_W = 5;

    typedef enum logic [SIZE_OPCODE_I-1:0] {
        MULT_L  = 6'h00,
        MULT_H  = 6'h01,
        MULTU_L = 6'h02,
        MULTU_H = 6'h03,
        DIV_L   = 6'h04,
        DIV_H   = 6'h05,
        DIVU_L  = 6'h06,
        DIVU_H  = 6'h07,
        SYSCALL = 6'h08
    } opcode_e;

    typedef struct packed {
        logic                           valid;
        logic [SIZE_DATA-1:0]           result;
        logic [EXECUTION_FLAGS-1:0]     flags;
        logic [SIZE_PHYSICAL_LOG-1:0]   tag;
        logic [SIZE_ACTIVELIST_LOG-1:0] rob;
    } wb_pkt_t;

    // Only the four divide opcodes use the long, non-pipelined divider;
    // everything else (including unknown encodings) is mult-class.
    function automatic logic is_div_op(input logic [SIZE_OPCODE_I-1:0] op);
        case (op)
            DIV_L, DIV_H, DIVU_L, DIVU_H: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/complex_exe_pipe_if.sv
// complex_exe_pipe_if
// Issue and writeback bus of the complex execution pipe.
//   Issue side : issue_valid_i, opcode_i, alu_result_i, alu_flags_i, tag_i, rob_i
//   Ready side : mult_ready_o, div_ready_o
//   Writeback  : wb_valid_o, wb_result_o, wb_flags_o, wb_tag_o, wb_rob_o
// Handshake: an op is accepted in a cycle when issue_valid_i is high and the
// ready of its class (mult_ready_o or div_ready_o) is high in that same cycle;
// the readies depend only on pipe state, never on the issue inputs. An issue
// presented while its ready is low is ignored and changes nothing.
// Modports: slave = the pipe, master = the issuing stage.
interface complex_exe_pipe_if;
    import complex_exe_pipe_pkg::*;

    logic                           issue_valid_i;
    logic [SIZE_OPCODE_I-1:0]       opcode_i;
    logic [SIZE_DATA-1:0]           alu_result_i;
    logic [EXECUTION_FLAGS-1:0]     alu_flags_i;
    logic [SIZE_PHYSICAL_LOG-1:0]   tag_i;
    logic [SIZE_ACTIVELIST_LOG-1:0] rob_i;

    logic                           mult_ready_o;
    logic                           div_ready_o;

    logic                           wb_valid_o;
    logic [SIZE_DATA-1:0]           wb_result_o;
    logic [EXECUTION_FLAGS-1:0]     wb_flags_o;
    logic [SIZE_PHYSICAL_LOG-1:0]   wb_tag_o;
    logic [SIZE_ACTIVELIST_LOG-1:0] wb_rob_o;

    modport slave (
        input  issue_valid_i, opcode_i, alu_result_i, alu_flags_i, tag_i, rob_i,
        output mult_ready_o, div_ready_o,
        output wb_valid_o, wb_result_o, wb_flags_o, wb_tag_o, wb_rob_o
    );

    modport master (
        output issue_valid_i, opcode_i, alu_result_i, alu_flags_i, tag_i, rob_i,
        input  mult_ready_o, div_ready_o,
        input  wb_valid_o, wb_result_o, wb_flags_o, wb_tag_o, wb_rob_o
    );

endinterface

// File: rtl/complex_mult_delay.sv
// complex_mult_delay
// Fixed-latency shift pipeline for mult-class writeback packets. Advances
// every cycle; DEPTH stages sit between the issue edge and the writeback
// register in the top, so DEPTH = MULT_LAT - 1 (DEPTH 0 is a wire).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear_i    : synchronous drop of every stage (flush)
//   in_i       : packet to capture (all-zero when nothing was accepted)
//   out_o      : oldest stage
module complex_mult_delay
    import complex_exe_pipe_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MULT_LAT - 1
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    clear_i,
    input  wb_pkt_t in_i,
    output wb_pkt_t out_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_o = in_i;
        end else begin : g_stages
            wb_pkt_t stage_q [DEPTH];
            wb_pkt_t stage_d [DEPTH];

            always_comb begin
                stage_d[0] = in_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else if (clear_i) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
                end
            end

            assign out_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/complex_exe_pipe.sv
// complex_exe_pipe
// Writeback timing for the complex execution unit. Mult-class ops (every
// opcode except the four divides) travel a MULT_LAT-cycle shift pipeline and
// may issue back-to-back. Div-class ops occupy a single holding register and
// a down-counter for DIV_LAT cycles; the divider is not pipelined.
// Parameters: MULT_LAT (1..7), DIV_LAT (> MULT_LAT, <= 31).
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-high reset, drops all in-flight ops
//   flush_i : only when COMPLEX_PIPE_FLUSH_EN is defined; drops all in-flight
//             ops and any same-cycle issue
//   bus     : complex_exe_pipe_if.slave (issue, readies, registered writeback)
// Optional feature macro: COMPLEX_PIPE_FLUSH_EN.
module complex_exe_pipe
    import complex_exe_pipe_pkg::*;
#(
    parameter int MULT_LAT = DEFAULT_MULT_LAT,
    parameter int DIV_LAT  = DEFAULT_DIV_LAT
) (
    input  logic clk,
    input  logic reset,
`ifdef COMPLEX_PIPE_FLUSH_EN
    input  logic flush_i,
`endif
    complex_exe_pipe_if.slave bus
);

    localparam logic [DIV_CNT_W-1:0] DIV_LOAD   = DIV_CNT_W'(DIV_LAT - 1);
    localparam logic [DIV_CNT_W-1:0] MULT_MATCH = DIV_CNT_W'(MULT_LAT);

    logic flush;
`ifdef COMPLEX_PIPE_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Remaining cycles until the in-flight div is presented on writeback;
    // zero means the divider is idle.
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
    wb_pkt_t              div_hold_q, div_hold_d;
    wb_pkt_t              wb_q, wb_d;

    wb_pkt_t issue_pkt;
    wb_pkt_t mult_in;
    wb_pkt_t mult_out;
    logic    issue_is_div;
    logic    div_busy;
    logic    div_done;
    logic    mult_ready;
    logic    div_ready;
    logic    mult_accept;
    logic    div_accept;

    assign issue_is_div = is_div_op(bus.opcode_i);
    assign div_busy     = (div_cnt_q != '0);
    assign div_done     = (div_cnt_q == DIV_CNT_W'(1));

    // A mult issued now writes back MULT_LAT cycles later; block it exactly
    // when that is the cycle the in-flight div writes back.
    assign div_ready  = !div_busy;
    assign mult_ready = !(div_busy && (div_cnt_q == MULT_MATCH));

    assign mult_accept = bus.issue_valid_i && !issue_is_div && mult_ready && !flush;
    assign div_accept  = bus.issue_valid_i &&  issue_is_div && div_ready  && !flush;

    assign issue_pkt = '{valid:  1'b1,
                         result: bus.alu_result_i,
                         flags:  bus.alu_flags_i,
                         tag:    bus.tag_i,
                         rob:    bus.rob_i};

    // Unaccepted cycles inject an all-zero packet so the pipeline payload is
    // already zero wherever valid is low.
    assign mult_in = mult_accept ? issue_pkt : '0;

    complex_mult_delay #(
        .DEPTH (MULT_LAT - 1)
    ) u_mult_delay (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .in_i    (mult_in),
        .out_o   (mult_out)
    );

    always_comb begin
        div_cnt_d  = div_cnt_q;
        div_hold_d = div_hold_q;
        wb_d       = '0;

        if (div_accept) begin
            div_cnt_d  = DIV_LOAD;
            div_hold_d = issue_pkt;
        end else if (div_busy) begin
            div_cnt_d = div_cnt_q - DIV_CNT_W'(1);
            if (div_done) begin
                div_hold_d = '0;
            end
        end

        // The ready rules guarantee mult and div never complete together.
        if (mult_out.valid) begin
            wb_d = mult_out;
        end else if (div_done) begin
            wb_d = div_hold_q;
        end

        if (flush) begin
            div_cnt_d  = '0;
            div_hold_d = '0;
            wb_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q  <= '0;
            div_hold_q <= '0;
            wb_q       <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            div_hold_q <= div_hold_d;
            wb_q       <= wb_d;
        end
    end

    assign bus.mult_ready_o = mult_ready;
    assign bus.div_ready_o  = div_ready;
    assign bus.wb_valid_o   = wb_q.valid;
    assign bus.wb_result_o  = wb_q.result;
    assign bus.wb_flags_o   = wb_q.flags;
    assign bus.wb_tag_o     = wb_q.tag;
    assign bus.wb_rob_o     = wb_q.rob;

endmodule

// File: tb/tb_complex_exe_pipe.sv
// tb_complex_exe_pipe
// Self-checking bench for complex_exe_pipe (MULT_LAT=3, DIV_LAT=8).
// Cycle n is the clock period in which an input is presented; an op issued
// in cycle c is expected on writeback in cycle c+latency. Writebacks are
// checked against a queue ordered by due cycle; optional flush sequence is
// compiled in with COMPLEX_PIPE_FLUSH_EN.
module tb_complex_exe_pipe;
    import complex_exe_pipe_pkg::*;

    localparam int ML = 3;
    localparam int DL = 8;
    localparam int EW = 16 + SIZE_DATA + EXECUTION_FLAGS + SIZE_PHYSICAL_LOG + SIZE_ACTIVELIST_LOG;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
`ifdef COMPLEX_PIPE_FLUSH_EN
    logic flush = 1'b0;
`endif
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    complex_exe_pipe_if bus ();

    complex_exe_pipe #(
        .MULT_LAT (ML),
        .DIV_LAT  (DL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef COMPLEX_PIPE_FLUSH_EN
        .flush_i (flush),
`endif
        .bus     (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    logic [EW-1:0] exp_q[$];
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
    endtask

    // Every writeback (or idle cycle) is compared in the middle of the cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.wb_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL wb_unexpected: got tag %0d rob %0d required no writeback (cycle %0d)",
                             bus.wb_tag_o, bus.wb_rob_o, cyc);
                end else begin
                    chk("wb_packet", {cyc[15:0], bus.wb_result_o, bus.wb_flags_o, bus.wb_tag_o, bus.wb_rob_o},
                        exp_q.pop_front());
                end
            end else begin
                chk("wb_idle_zero", {16'h0, bus.wb_result_o, bus.wb_flags_o, bus.wb_tag_o, bus.wb_rob_o}, '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present one op in the current cycle. lat tells the op's class (ML or DL);
    // exp_acc is whether the bench expects that class to be ready now.
    task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic [5:0] fl,
                         input logic [5:0] tg, input logic [4:0] rb, input int lat, input bit exp_acc);
        int due;
        int pos;
        logic [EW-1:0] e;
        if (lat == DL) chk_bit("div_ready_at_issue", bus.div_ready_o, exp_acc);
        else           chk_bit("mult_ready_at_issue", bus.mult_ready_o, exp_acc);
        bus.issue_valid_i = 1'b1;
        bus.opcode_i      = op;
        bus.alu_result_i  = res;
        bus.alu_flags_i   = fl;
        bus.tag_i         = tg;
        bus.rob_i         = rb;
        if (exp_acc) begin
            due = cyc + lat;
            e   = {due[15:0], res, fl, tg, rb};
            pos = exp_q.size();
            for (int j = exp_q.size() - 1; j >= 0; j--) begin
                if (exp_q[j][EW-1 -: 16] > due[15:0]) pos = j;
            end
            exp_q.insert(pos, e);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [5:0]  op;
        logic [31:0] res;
        logic [5:0]  fl;
        logic [5:0]  tg;
        logic [4:0]  rb;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int  div_due;
        bit  exp_dr;
        bit  exp_mr;
        int  sel;
        bit  acc;

        bus.issue_valid_i = 1'b0;
        bus.opcode_i      = '0;
        bus.alu_result_i  = '0;
        bus.alu_flags_i   = '0;
        bus.tag_i         = '0;
        bus.rob_i         = '0;

        vecs[0].op = MULT_L;  vecs[0].lat = ML;
        vecs[1].op = MULT_H;  vecs[1].lat = ML;
        vecs[2].op = MULTU_L; vecs[2].lat = ML;
        vecs[3].op = MULTU_H; vecs[3].lat = ML;
        vecs[4].op = DIV_L;   vecs[4].lat = DL;
        vecs[5].op = DIV_H;   vecs[5].lat = DL;
        vecs[6].op = DIVU_L;  vecs[6].lat = DL;
        vecs[7].op = DIVU_H;  vecs[7].lat = DL;
        vecs[8].op = SYSCALL; vecs[8].lat = ML;
        vecs[9].op = 6'h2a;   vecs[9].lat = ML;
        for (int i = 0; i < 10; i++) begin
            vecs[i].res = $urandom;
            vecs[i].fl  = 6'($urandom_range(0, 63));
            vecs[i].tg  = 6'($urandom_range(0, 63));
            vecs[i].rb  = 5'($urandom_range(0, 31));
        end

        // Reset state
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("rst_mult_ready", bus.mult_ready_o, 1'b1);
        chk_bit("rst_div_ready", bus.div_ready_o, 1'b1);
        chk_bit("rst_wb_valid", bus.wb_valid_o, 1'b0);
        chk("rst_wb_data", {16'h0, bus.wb_result_o, bus.wb_flags_o, bus.wb_tag_o, bus.wb_rob_o}, '0);
        reset  = 1'b0;
        mon_en = 1'b1;
        step();

        // Single mult: result 6, tag 5, flags 011100 three cycles later
        issue(MULT_L, 32'h0000_0006, 6'b011100, 6'd5, 5'd0, ML, 1'b1);
        step();
        drain(ML + 2);

        // Four back-to-back mults, tags 1..4
        for (int i = 1; i <= 4; i++) begin
            issue(MULT_L, $urandom, 6'($urandom_range(0, 63)), 6'(i), 5'(i), ML, 1'b1);
            step();
        end
        drain(ML + 2);

        // DIVU_L rob 9; div_ready low for 7 cycles, second div ignored
        issue(DIVU_L, $urandom, 6'b000101, 6'd7, 5'd9, DL, 1'b1);
        step();
        for (int k = 1; k <= 8; k++) begin
            chk_bit("div_busy_ready", bus.div_ready_o, (k == 8));
            if (k == 2) issue(DIV_L, $urandom, 6'd1, 6'd8, 5'd10, DL, 1'b0);
            step();
        end
        drain(3);

        // Div then mults around the collision slot
        issue(DIV_H, $urandom, 6'd2, 6'd20, 5'd20, DL, 1'b1);
        step();
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) issue(MULT_H,  $urandom, 6'd3, 6'd21, 5'd21, ML, 1'b1);
            if (k == 5) issue(MULTU_L, $urandom, 6'd4, 6'd22, 5'd22, ML, 1'b0);
            if (k == 6) issue(SYSCALL, $urandom, 6'd5, 6'd23, 5'd23, ML, 1'b1);
            step();
        end
        drain(6);

        // Reset while a writeback is showing with mult and div in flight
        issue(MULT_L, 32'hdead_beef, 6'd7, 6'd30, 5'd30, ML, 1'b1);
        step();
        issue(MULT_H, 32'h1234_5678, 6'd8, 6'd31, 5'd31, ML, 1'b1);
        step();
        issue(DIV_L, 32'hcafe_f00d, 6'd9, 6'd32, 5'd1, DL, 1'b1);
        step();
        #2;
        chk_bit("pre_reset_wb_valid", bus.wb_valid_o, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk_bit("async_rst_wb_valid", bus.wb_valid_o, 1'b0);
        chk("async_rst_wb_data", {16'h0, bus.wb_result_o, bus.wb_flags_o, bus.wb_tag_o, bus.wb_rob_o}, '0);
        chk_bit("async_rst_mult_ready", bus.mult_ready_o, 1'b1);
        chk_bit("async_rst_div_ready", bus.div_ready_o, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drain(DL + 4);

        // Table: every opcode class in isolation
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].res, vecs[i].fl, vecs[i].tg, vecs[i].rb, vecs[i].lat, 1'b1);
            step();
            drain(vecs[i].lat + 1);
        end

        // Random mixed stream against a ready model
        div_due = -1;
        for (int k = 0; k < 60; k++) begin
            exp_dr = !(div_due >= 0 && cyc < div_due);
            exp_mr = !(div_due >= 0 && (div_due - cyc) == ML);
            chk_bit("rand_div_ready", bus.div_ready_o, exp_dr);
            chk_bit("rand_mult_ready", bus.mult_ready_o, exp_mr);
            if ($urandom_range(0, 3) != 0) begin
                sel = $urandom_range(0, 9);
                acc = (vecs[sel].lat == DL) ? exp_dr : exp_mr;
                issue(vecs[sel].op, $urandom, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                      5'($urandom_range(0, 31)), vecs[sel].lat, acc);
                if (vecs[sel].lat == DL && acc) div_due = cyc + DL;
            end
            step();
        end
        drain(DL + 4);

`ifdef COMPLEX_PIPE_FLUSH_EN
        // Flush with a div and a mult in flight plus a same-cycle mult issue
        issue(DIV_L, $urandom, 6'd1, 6'd40, 5'd11, DL, 1'b1);
        step();
        issue(MULT_L, $urandom, 6'd2, 6'd41, 5'd12, ML, 1'b1);
        step();
        bus.issue_valid_i = 1'b1;
        bus.opcode_i      = MULT_H;
        bus.tag_i         = 6'd42;
        flush             = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        chk_bit("flush_mult_ready", bus.mult_ready_o, 1'b1);
        chk_bit("flush_div_ready", bus.div_ready_o, 1'b1);
        drain(DL + 4);
`endif

        mon_en = 1'b0;
        chk("scoreboard_empty", EW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
